// File: rtl/vlc_manchester_tx.sv
// VLC frame transmitter: preamble, SFD and payload bytes, Manchester-coded onto led_out.
// Build macro VLC_PARITY_EN appends an even-parity bit after every payload byte.
module vlc_manchester_tx #(
  parameter int         DIV_WIDTH = 10,
  parameter int         PRE_LEN   = 8,
  parameter logic [7:0] SFD       = 8'hA5
) (
  input  logic                 c_clk,
  input  logic                 c_reset_n,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [7:0]           tx_data,
  input  logic                 tx_valid,
  input  logic                 tx_last,
  output logic                 tx_ready,
  output logic                 led_out,
  output logic                 sym_tick,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_underrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRE, ST_SFD, ST_DATA} state_t;

  localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
`ifdef VLC_PARITY_EN
  localparam logic [7:0] BYTE_LAST = 8'd8;
`else
  localparam logic [7:0] BYTE_LAST = 8'd7;
`endif

  state_t               state;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] div_lat;
  logic                 half;
  logic [7:0]           bit_cnt;
  logic [7:0]           shreg;
  logic [7:0]           hold_data;
  logic                 hold_valid;
  logic                 hold_last;
  logic                 cur_last;
`ifdef VLC_PARITY_EN
  logic                 parity;
`endif
  logic                 transfer;
  logic                 start;
  logic                 half_end;
  logic                 bit_end;
  logic                 byte_end;
  logic                 take;
  logic                 bit_val;
  logic                 next_val;

  assign tx_ready = !hold_valid;
  assign busy     = (state != ST_IDLE);
  assign transfer = tx_valid && tx_ready;
  assign start    = (state == ST_IDLE) && en && hold_valid;
  assign half_end = en && (state != ST_IDLE) && (presc == div_lat);
  assign bit_end  = half_end && half;
  assign byte_end = (state == ST_DATA) && (bit_cnt == BYTE_LAST);
  assign take     = bit_end && (((state == ST_SFD) && (bit_cnt == 8'd7)) ||
                                (byte_end && !cur_last && hold_valid));

  // bit_val is the bit on the line now; next_val is the first half of the bit that follows it
  always_comb begin
    bit_val  = 1'b1;
    next_val = 1'b0;
    case (state)
      ST_PRE: next_val = (bit_cnt == PRE_LAST) ? SFD[7] : 1'b1;
      ST_SFD: begin
        bit_val  = shreg[7];
        next_val = (bit_cnt == 8'd7) ? hold_data[7] : shreg[6];
      end
      ST_DATA: begin
        bit_val = shreg[7];
        if (byte_end)
          next_val = (!cur_last && hold_valid) ? hold_data[7] : 1'b0;
        else
          next_val = shreg[6];
`ifdef VLC_PARITY_EN
        if (bit_cnt == 8'd8)
          bit_val = parity;
        if (bit_cnt == 8'd7)
          next_val = parity;
`endif
      end
      default: ;
    endcase
  end

  // Holding register keeps handshaking even while en is low
  always_ff @(posedge c_clk or negedge c_reset_n) begin
    if (!c_reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'd0;
      hold_last  <= 1'b0;
    end else if (transfer) begin
      hold_valid <= 1'b1;
      hold_data  <= tx_data;
      hold_last  <= tx_last;
    end else if (take) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge c_clk or negedge c_reset_n) begin
    if (!c_reset_n) begin
      state        <= ST_IDLE;
      presc        <= '0;
      div_lat      <= '0;
      half         <= 1'b0;
      bit_cnt      <= 8'd0;
      shreg        <= 8'd0;
      cur_last     <= 1'b0;
`ifdef VLC_PARITY_EN
      parity       <= 1'b0;
`endif
      led_out      <= 1'b0;
      sym_tick     <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
    end else begin
      sym_tick     <= 1'b0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      if (start) begin
        state   <= ST_PRE;
        div_lat <= div;
        presc   <= '0;
        half    <= 1'b0;
        bit_cnt <= 8'd0;
        led_out <= 1'b1;
      end else if (half_end && !half) begin
        presc   <= '0;
        half    <= 1'b1;
        led_out <= ~bit_val;
      end else if (bit_end) begin
        presc    <= '0;
        half     <= 1'b0;
        sym_tick <= 1'b1;
        bit_cnt  <= bit_cnt + 8'd1;
        led_out  <= next_val;
        shreg    <= {shreg[6:0], 1'b0};
        case (state)
          ST_PRE: begin
            if (bit_cnt == PRE_LAST) begin
              state   <= ST_SFD;
              bit_cnt <= 8'd0;
              shreg   <= SFD;
            end
          end
          ST_SFD: begin
            if (bit_cnt == 8'd7) begin
              state    <= ST_DATA;
              bit_cnt  <= 8'd0;
              shreg    <= hold_data;
              cur_last <= hold_last;
`ifdef VLC_PARITY_EN
              parity   <= ^hold_data;
`endif
            end
          end
          ST_DATA: begin
            if (byte_end) begin
              bit_cnt <= 8'd0;
              if (cur_last) begin
                frame_done <= 1'b1;
                state      <= ST_IDLE;
              end else if (hold_valid) begin
                shreg    <= hold_data;
                cur_last <= hold_last;
`ifdef VLC_PARITY_EN
                parity   <= ^hold_data;
`endif
              end else begin
                err_underrun <= 1'b1;
                state        <= ST_IDLE;
              end
            end
          end
          default: ;
        endcase
      end else if (en && (state != ST_IDLE)) begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vlc_manchester_tx.sv
// Self-checking bench for vlc_manchester_tx: directed and random frames against a bit-list reference model.
module tb_vlc_manchester_tx;

  localparam int         DIV_WIDTH = 10;
  localparam int         PRE_LEN   = 8;
  localparam logic [7:0] SFD_VAL   = 8'hA5;

  logic                 c_clk = 1'b0;
  logic                 c_reset_n;
  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_last;
  logic                 tx_ready;
  logic                 led_out;
  logic                 sym_tick;
  logic                 busy;
  logic                 frame_done;
  logic                 err_underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame_bytes[$];
  bit         give_last;
  int         div_val;
  int         gap_cycles;
  int         gap_start;

  logic cap_led[$];
  int   cap_ticks;
  int   cap_done;
  int   cap_err;
  int   cap_busy_cycles;
  bit   cap_timeout;

  logic exp_led[$];
  int   exp_bits;

  logic en_at_edge;

  vlc_manchester_tx #(
    .DIV_WIDTH(DIV_WIDTH),
    .PRE_LEN  (PRE_LEN),
    .SFD      (SFD_VAL)
  ) dut (
    .c_clk       (c_clk),
    .c_reset_n   (c_reset_n),
    .en          (en),
    .div         (div),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .led_out     (led_out),
    .sym_tick    (sym_tick),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_underrun(err_underrun)
  );

  always #5 c_clk = ~c_clk;

  // Remember whether the line was allowed to advance at the last rising edge
  always @(posedge c_clk) en_at_edge = en;

  // Reference: list of transmitted bits, each expanded into two halves of div+1 clocks
  function automatic void buildModel();
    logic       bits[$];
    logic [7:0] b;
    logic [7:0] s;
    bits = {};
    s = SFD_VAL;
    for (int i = 0; i < PRE_LEN; i++) bits.push_back(1'b1);
    for (int i = 7; i >= 0; i--) bits.push_back(s[i]);
    foreach (frame_bytes[k]) begin
      b = frame_bytes[k];
      for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
`ifdef VLC_PARITY_EN
      bits.push_back(^b);
`endif
    end
    exp_bits = bits.size();
    exp_led = {};
    foreach (bits[j]) begin
      for (int h = 0; h <= div_val; h++) exp_led.push_back(bits[j]);
      for (int h = 0; h <= div_val; h++) exp_led.push_back(~bits[j]);
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Feed the frame bytes, capture the line and pulses, and optionally drop en mid-frame
  task automatic applyStimulus();
    int  src_guard;
    bit  sent;
    int  wait_n;
    int  run_n;
    cap_led = {};
    cap_ticks = 0;
    cap_done = 0;
    cap_err = 0;
    cap_busy_cycles = 0;
    cap_timeout = 0;
    div = DIV_WIDTH'(div_val);
    fork
      begin
        for (int i = 0; i < frame_bytes.size(); i++) begin
          @(negedge c_clk);
          tx_data  = frame_bytes[i];
          tx_last  = give_last && (i == frame_bytes.size() - 1);
          tx_valid = 1'b1;
          sent = 0;
          src_guard = 0;
          while (!sent && src_guard < 5000) begin
            sent = tx_ready;
            @(posedge c_clk);
            src_guard++;
            if (!sent) @(negedge c_clk);
          end
        end
        @(negedge c_clk);
        tx_valid = 1'b0;
        tx_last  = 1'b0;
      end
      begin
        wait_n = 0;
        @(negedge c_clk);
        while (!busy && wait_n < 200) begin
          @(negedge c_clk);
          wait_n++;
        end
        if (!busy) begin
          cap_timeout = 1;
        end else begin
          run_n = 0;
          while (busy && run_n < 20000) begin
            if (en_at_edge) cap_led.push_back(led_out);
            cap_busy_cycles++;
            if (sym_tick === 1'b1) cap_ticks++;
            if (frame_done === 1'b1) cap_done++;
            if (err_underrun === 1'b1) cap_err++;
            @(negedge c_clk);
            run_n++;
          end
          if (busy) cap_timeout = 1;
          repeat (4) begin
            if (sym_tick === 1'b1) cap_ticks++;
            if (frame_done === 1'b1) cap_done++;
            if (err_underrun === 1'b1) cap_err++;
            @(negedge c_clk);
          end
        end
      end
      begin
        if (gap_cycles > 0) begin
          repeat (gap_start) @(negedge c_clk);
          en = 1'b0;
          repeat (gap_cycles) @(negedge c_clk);
          en = 1'b1;
        end
      end
    join
  endtask

  task automatic checkFrame(input string tag);
    int mism;
    buildModel();
    mism = 0;
    for (int i = 0; i < exp_led.size(); i++)
      if (i >= cap_led.size() || cap_led[i] !== exp_led[i]) mism++;
    checkOutput({tag, " timeout"}, 32'(cap_timeout), 32'd0);
    checkOutput({tag, " line length"}, cap_led.size(), exp_led.size());
    checkOutput({tag, " line halves wrong"}, mism, 32'd0);
    checkOutput({tag, " sym_tick count"}, cap_ticks, exp_bits);
    checkOutput({tag, " frame_done count"}, cap_done, give_last ? 32'd1 : 32'd0);
    checkOutput({tag, " err_underrun count"}, cap_err, give_last ? 32'd0 : 32'd1);
    checkOutput({tag, " busy cycles"}, cap_busy_cycles, exp_led.size() + gap_cycles);
    checkOutput({tag, " led idle"}, 32'(led_out), 32'd0);
    checkOutput({tag, " tx_ready idle"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] sfd_halves;
    logic [15:0] pay_halves;
    int          nb;
    c_reset_n  = 1'b0;
    en         = 1'b1;
    div        = '0;
    tx_data    = 8'd0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    gap_cycles = 0;
    gap_start  = 0;

    // Reset state
    repeat (2) @(negedge c_clk);
    checkOutput("reset tx_ready", 32'(tx_ready), 32'd1);
    checkOutput("reset led_out", 32'(led_out), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset pulses", {29'd0, sym_tick, frame_done, err_underrun}, 32'd0);
    c_reset_n = 1'b1;
    repeat (2) @(negedge c_clk);

    // Single byte frame, div=1
    $display("[TB] single byte 3C div=1");
    div_val = 1; give_last = 1; frame_bytes = {8'h3C};
    applyStimulus();
    checkFrame("single");

    // Back-to-back three bytes
    $display("[TB] back-to-back 00 FF 81");
    div_val = 1; give_last = 1; frame_bytes = {8'h00, 8'hFF, 8'h81};
    applyStimulus();
    checkFrame("b2b");

    // Underrun
    $display("[TB] underrun 55");
    div_val = 1; give_last = 0; frame_bytes = {8'h55};
    applyStimulus();
    checkFrame("underrun");
    checkOutput("underrun busy", 32'(busy), 32'd0);

    // div=0 with payload equal to the SFD
    $display("[TB] div=0 payload A5");
    div_val = 0; give_last = 1; frame_bytes = {8'hA5};
    applyStimulus();
    checkFrame("div0");
    for (int i = 0; i < 16; i++) begin
      sfd_halves[15-i] = cap_led[16+i];
      pay_halves[15-i] = cap_led[32+i];
    end
    checkOutput("div0 SFD halves", 32'(sfd_halves), 32'h9966);
    checkOutput("div0 payload halves", 32'(pay_halves), 32'h9966);

    // en low for 7 cycles in the middle of the payload
    $display("[TB] en gap mid-DATA");
    div_val = 1; give_last = 1; frame_bytes = {8'hC6};
    gap_cycles = 7; gap_start = 80;
    applyStimulus();
    checkFrame("en gap");
    gap_cycles = 0;

    // Reset pulse during SFD
    $display("[TB] reset mid-SFD");
    div = DIV_WIDTH'(1);
    @(negedge c_clk);
    tx_data = 8'h5A; tx_last = 1'b1; tx_valid = 1'b1;
    @(negedge c_clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    repeat (44) @(negedge c_clk);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    c_reset_n = 1'b0;
    #1;
    checkOutput("mid reset led_out", 32'(led_out), 32'd0);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    checkOutput("mid reset tx_ready", 32'(tx_ready), 32'd1);
    @(negedge c_clk);
    c_reset_n = 1'b1;
    div_val = 2; give_last = 1; frame_bytes = {8'h96};
    applyStimulus();
    checkFrame("after reset");

    // Parity-relevant byte (parity=1 when enabled)
    $display("[TB] byte 07");
    div_val = 1; give_last = 1; frame_bytes = {8'h07};
    applyStimulus();
    checkFrame("byte07");

    // Randomized frames
    for (int r = 0; r < 5; r++) begin
      div_val = $urandom_range(0, 3);
      nb = $urandom_range(1, 3);
      give_last = ($urandom_range(0, 3) != 0);
      frame_bytes = {};
      for (int k = 0; k < nb; k++) frame_bytes.push_back(8'($urandom));
      $display("[TB] random frame %0d: div=%0d bytes=%0d last=%0d", r, div_val, nb, give_last);
      applyStimulus();
      checkFrame("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
